// File: rtl/dift_trap_ctrl.sv
// DIFT tag-check trap receiver: latches cause/EPC, holds the request until ack, then tracks the handler until return.
// Optional per-type accepted-trap counters are enabled by defining DIFT_TRAP_COUNT_EN.
module dift_trap_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_i,
  input  logic [2:0]        trap_type_i,
  input  logic [31:0]       trap_pc_i,
  input  logic              trap_ack_i,
  input  logic              trap_ret_i,
  input  logic              csr_clr_i,
  input  logic [2:0]        cnt_sel_i,
  output logic              trap_req_o,
  output logic [2:0]        trap_cause_o,
  output logic [31:0]       trap_epc_o,
  output logic              handler_active_o,
  output logic              missed_o,
  output logic [CNT_W-1:0]  cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        missed_q, missed_d;
  logic        trap_valid;
  logic        accept;
  logic        drop;

  // Types 5-7 are not defined trap types and are ignored completely.
  assign trap_valid = trap_i && (trap_type_i <= 3'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cause_q  <= 3'd0;
      epc_q    <= 32'd0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      missed_q <= missed_d;
    end
  end

  // Only one trap may be outstanding; a return frees the slot in the same cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (trap_valid) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (trap_ack_i) state_d = HANDLER;
        if (trap_valid) drop = 1'b1;
      end
      HANDLER: begin
        if (trap_ret_i) begin
          if (trap_valid) begin
            accept  = 1'b1;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (trap_valid) begin
          drop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cause_d  = accept ? trap_type_i : cause_q;
    epc_d    = accept ? trap_pc_i : epc_q;
    missed_d = csr_clr_i ? 1'b0 : (drop ? 1'b1 : missed_q);
  end

  always_comb begin
    trap_req_o       = (state_q == REQ);
    handler_active_o = (state_q == HANDLER);
    trap_cause_o     = cause_q;
    trap_epc_o       = epc_q;
    missed_o         = missed_q;
  end

`ifdef DIFT_TRAP_COUNT_EN
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Clear takes priority over a same-cycle increment; counters saturate at all-ones.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = cnt_q[i];
      if (csr_clr_i) begin
        cnt_d[i] = '0;
      end else if (accept && (trap_type_i == 3'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_o = '0;
    if (cnt_sel_i <= 3'd4) cnt_o = cnt_q[cnt_sel_i];
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel_i;
  assign cnt_o = '0;
`endif

endmodule
